// File: rtl/image_loader.sv
// image_loader: frames a 28x28 image plus label from the uart byte
// stream, buffers it raw, then streams Q16.15 pixels to conv1.
module image_loader #(
  parameter int          IMG_W   = 28,
  parameter int          IMG_H   = 28,
  parameter logic [7:0]  HEADER  = 8'hA5,
  parameter int          TIMEOUT = 1000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx_ready,
  input  logic [7:0]  rx_data,
  output logic        pix_valid,
  input  logic        pix_ready,
  output logic [31:0] pix_data,
  output logic [4:0]  pix_x,
  output logic [4:0]  pix_y,
  output logic        pix_last,
  output logic [3:0]  label,
  output logic        label_valid,
  output logic        busy,
  output logic        overrun,
  output logic        frame_err
);

  localparam int NPIX = IMG_W * IMG_H;
  localparam int AW   = $clog2(NPIX);
  localparam int TW   = $clog2(TIMEOUT + 1);

  localparam logic [AW-1:0] LAST_A = AW'(NPIX - 1);
  localparam logic [TW-1:0] TMO_L  = TW'(TIMEOUT - 1);
  localparam logic [4:0]    XL     = 5'(IMG_W - 1);
  localparam logic [4:0]    YL     = 5'(IMG_H - 1);

  typedef enum logic [1:0] {
    IDLE,
    RECV,
    LABEL,
    STREAM
  } state_t;

  state_t state, state_nxt;

  logic [7:0]    mem [NPIX];
  logic [AW-1:0] wr_addr;
  logic [AW-1:0] rd_addr;
  logic [4:0]    sx;
  logic [4:0]    sy;
  logic [TW-1:0] tcnt;

  logic in_frame;
  logic hdr_hit;
  logic recv_done;
  logic lbl_ok;
  logic lbl_bad;
  logic tmo;
  logic adv;
  logic last_hs;
  logic err_nxt;

  // Offset-binary byte to signed Q16.15: (b - 128) / 128.
  function automatic logic [31:0] to_q15(input logic [7:0] b);
    logic [7:0] s;
    s = b ^ 8'h80;
    return {{16{s[7]}}, s, 8'h00};
  endfunction

  // Event decode shared by the FSM and the datapath.
  always_comb begin
    in_frame  = (state == RECV) || (state == LABEL);
    hdr_hit   = (state == IDLE) && rx_ready
                && (rx_data == HEADER);
    recv_done = (state == RECV) && rx_ready
                && (wr_addr == LAST_A);
    lbl_ok    = (state == LABEL) && rx_ready
                && (rx_data <= 8'd9);
    lbl_bad   = (state == LABEL) && rx_ready
                && (rx_data > 8'd9);
    tmo       = in_frame && !rx_ready
                && (tcnt == TMO_L);
    adv       = (state == STREAM)
                && (!pix_valid || pix_ready);
    last_hs   = adv && pix_valid && pix_last;
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:   if (hdr_hit) state_nxt = RECV;
      RECV: begin
        if (tmo)            state_nxt = IDLE;
        else if (recv_done) state_nxt = LABEL;
      end
      LABEL: begin
        if (tmo)          state_nxt = IDLE;
        else if (lbl_ok)  state_nxt = STREAM;
        else if (lbl_bad) state_nxt = IDLE;
      end
      STREAM: if (last_hs) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State-derived outputs and error strobe source.
  always_comb begin
    busy    = (state != IDLE);
    err_nxt = tmo || lbl_bad;
  end

  // Raw frame buffer; contents survive reset.
  always_ff @(posedge clk) begin
    if ((state == RECV) && rx_ready)
      mem[wr_addr] <= rx_data;
  end

  // Write index and inter-byte timeout counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_addr <= '0;
      tcnt    <= '0;
    end else if (hdr_hit) begin
      wr_addr <= '0;
      tcnt    <= '0;
    end else if (in_frame) begin
      if (rx_ready) tcnt <= '0;
      else          tcnt <= tcnt + 1'b1;
      if ((state == RECV) && rx_ready)
        wr_addr <= wr_addr + 1'b1;
    end else begin
      tcnt <= '0;
    end
  end

  // Label, sticky overrun and error pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      label       <= '0;
      label_valid <= 1'b0;
      overrun     <= 1'b0;
      frame_err   <= 1'b0;
    end else begin
      frame_err <= err_nxt;
      if (hdr_hit) label_valid <= 1'b0;
      if (lbl_ok) begin
        label       <= rx_data[3:0];
        label_valid <= 1'b1;
      end
      if ((state == STREAM) && rx_ready)
        overrun <= 1'b1;
    end
  end

  // Output pixel register: reload when empty or just consumed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pix_valid <= 1'b0;
      pix_data  <= '0;
      pix_x     <= '0;
      pix_y     <= '0;
      pix_last  <= 1'b0;
      rd_addr   <= '0;
      sx        <= '0;
      sy        <= '0;
    end else if (lbl_ok) begin
      rd_addr <= '0;
      sx      <= '0;
      sy      <= '0;
    end else if (last_hs) begin
      pix_valid <= 1'b0;
      pix_last  <= 1'b0;
    end else if (adv) begin
      pix_valid <= 1'b1;
      pix_data  <= to_q15(mem[rd_addr]);
      pix_x     <= sx;
      pix_y     <= sy;
      pix_last  <= (sx == XL) && (sy == YL);
      rd_addr   <= rd_addr + 1'b1;
      if (sx == XL) begin
        sx <= '0;
        sy <= sy + 5'd1;
      end else begin
        sx <= sx + 5'd1;
      end
    end
  end

endmodule
